// File: rtl/tt_um_emern_scanout.sv
// tt_um_emern_scanout: parametrised video scanout.
//   Raster counters, sync/blank generation aligned to the pixel-core latency,
//   and blank gating of the colour bus.
//   Optional feature macro: TEST_PATTERN_EN (adds test_en and 8 vertical colour bars).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pixel_in          colour for the counter value issued PIPE cycles earlier
//   test_en           selects internal colour bars (TEST_PATTERN_EN only)
//   col, row          raster counters
//   screen_inactive   col/row outside the visible area (aligned to col/row)
//   cmd_en            vertical blank load window (aligned to col/row)
//   frame_irq         one-cycle pulse at row==V_ACTIVE, col==0
//   h_sync, v_sync    sync outputs, aligned to rgb_out
//   rgb_out           gated colour {R,G,B}, zero during blank
module tt_um_emern_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CBITS    = 2,
    parameter int unsigned PIPE     = 1,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned CW      = $clog2(H_TOTAL),
    localparam int unsigned RW      = $clog2(V_TOTAL),
    localparam int unsigned PW      = 3 * CBITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] pixel_in,
`ifdef TEST_PATTERN_EN
    input  logic          test_en,
`endif
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          screen_inactive,
    output logic          cmd_en,
    output logic          frame_irq,
    output logic          h_sync,
    output logic          v_sync,
    output logic [PW-1:0] rgb_out
);

    logic          hs_act;
    logic          vs_act;
    logic          hs_d;
    logic          vs_d;
    logic          blank_d;
    logic [PW-1:0] pix_src;

    wire col_last = (col == CW'(H_TOTAL - 1));

    // Raster counters; frame_irq is registered one cycle ahead of its position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            frame_irq <= 1'b0;
        end else begin
            frame_irq <= col_last && (row == RW'(V_ACTIVE - 1));
            if (col_last) begin
                col <= '0;
                row <= (row == RW'(V_TOTAL - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Undelayed decodes
    assign screen_inactive = (col >= CW'(H_ACTIVE)) || (row >= RW'(V_ACTIVE));
    assign cmd_en          = (row >= RW'(V_ACTIVE));
    assign hs_act          = (col >= CW'(H_ACTIVE + H_FP)) && (col < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act          = (row >= RW'(V_ACTIVE + V_FP)) && (row < RW'(V_ACTIVE + V_FP + V_SYNC));

`ifdef TEST_PATTERN_EN
    logic [CW-1:0] col_d;
`endif

    // Delay line matching the pixel-core latency
    generate
        if (PIPE == 0) begin : g_nopipe
            assign hs_d    = hs_act;
            assign vs_d    = vs_act;
            assign blank_d = screen_inactive;
`ifdef TEST_PATTERN_EN
            assign col_d   = col;
`endif
        end else begin : g_pipe
            logic [PIPE-1:0] hs_q;
            logic [PIPE-1:0] vs_q;
            logic [PIPE-1:0] blank_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_q    <= '0;
                    vs_q    <= '0;
                    blank_q <= '1;
                end else begin
                    hs_q    <= PIPE'({hs_q, hs_act});
                    vs_q    <= PIPE'({vs_q, vs_act});
                    blank_q <= PIPE'({blank_q, screen_inactive});
                end
            end

            assign hs_d    = hs_q[PIPE-1];
            assign vs_d    = vs_q[PIPE-1];
            assign blank_d = blank_q[PIPE-1];

`ifdef TEST_PATTERN_EN
            logic [CW-1:0] col_q [PIPE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(PIPE); i++) col_q[i] <= '0;
                end else begin
                    col_q[0] <= col;
                    for (int i = 1; i < int'(PIPE); i++) col_q[i] <= col_q[i-1];
                end
            end

            assign col_d = col_q[PIPE-1];
`endif
        end
    endgenerate

`ifdef TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    // Bar index from the delayed column; each bit of it lights one channel
    logic [CW-1:0] bar_idx;
    logic [PW-1:0] bar_rgb;
    assign bar_idx = col_d / CW'(BAR_W);
    assign bar_rgb = {{CBITS{bar_idx[2]}}, {CBITS{bar_idx[1]}}, {CBITS{bar_idx[0]}}};
    assign pix_src = test_en ? bar_rgb : pixel_in;
`else
    assign pix_src = pixel_in;
`endif

    // Output register: blank gating and sync polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
            h_sync  <= ~HS_POL;
            v_sync  <= ~VS_POL;
        end else begin
            rgb_out <= blank_d ? '0 : pix_src;
            h_sync  <= hs_d ? HS_POL : ~HS_POL;
            v_sync  <= vs_d ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_tt_um_emern_scanout.sv
// Bench for tt_um_emern_scanout: default timing (PIPE=1), PIPE=3, and a small
// raster (HS_POL=1) that makes whole frames cheap to walk through.
module tb_tt_um_emern_scanout;

    logic clk;
    logic rst_n;
    bit   tp;
    int   n;
    int   checks;
    int   failures;

    logic [9:0] b_col, b_row, p_col, p_row;
    logic [4:0] s_col;
    logic [3:0] s_row;
    logic [5:0] b_rgb, p_rgb, s_rgb;
    logic b_si, b_cmd, b_fi, b_hs, b_vs;
    logic p_si, p_cmd, p_fi, p_hs, p_vs;
    logic s_si, s_cmd, s_fi, s_hs, s_vs;

    tt_um_emern_scanout u_big (
        .clk(clk), .rst_n(rst_n), .pixel_in(6'h3F),
`ifdef TEST_PATTERN_EN
        .test_en(tp),
`endif
        .col(b_col), .row(b_row), .screen_inactive(b_si), .cmd_en(b_cmd),
        .frame_irq(b_fi), .h_sync(b_hs), .v_sync(b_vs), .rgb_out(b_rgb)
    );

    tt_um_emern_scanout #(.PIPE(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .pixel_in(6'h2A),
`ifdef TEST_PATTERN_EN
        .test_en(tp),
`endif
        .col(p_col), .row(p_row), .screen_inactive(p_si), .cmd_en(p_cmd),
        .frame_irq(p_fi), .h_sync(p_hs), .v_sync(p_vs), .rgb_out(p_rgb)
    );

    tt_um_emern_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(1)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .pixel_in(6'h15),
`ifdef TEST_PATTERN_EN
        .test_en(tp),
`endif
        .col(s_col), .row(s_row), .screen_inactive(s_si), .cmd_en(s_cmd),
        .frame_irq(s_fi), .h_sync(s_hs), .v_sync(s_vs), .rgb_out(s_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, exp, n);
        end
    endtask

    function automatic logic [5:0] bar(input int c, input int w);
        int k;
        k = c / w;
        return {{2{k[2]}}, {2{k[1]}}, {2{k[0]}}};
    endfunction

    // Expected delayed outputs n cycles after reset release
    function automatic void model(input int nn, input int lat,
                                  input int ha, input int hf, input int hsy, input int ht,
                                  input int va, input int vf, input int vsy, input int vt,
                                  input bit hpol, input bit vpol, input logic [5:0] pix,
                                  output logic [5:0] rgb, output logic h, output logic v);
        int m, c, r;
        if (nn < lat + 1) begin
            rgb = 6'h00;
            h   = !hpol;
            v   = !vpol;
        end else begin
            m   = nn - lat - 1;
            c   = m % ht;
            r   = (m / ht) % vt;
            rgb = (c < ha && r < va) ? (tp ? bar(c, ha / 8) : pix) : 6'h00;
            h   = (c >= ha + hf && c < ha + hf + hsy) ? hpol : !hpol;
            v   = (r >= va + vf && r < va + vf + vsy) ? vpol : !vpol;
        end
    endfunction

    task automatic chk_cnt(input string p, input int ht, input int vt, input int ha, input int va,
                           input logic [31:0] col, input logic [31:0] row,
                           input logic si, input logic cmd, input logic fi);
        int c, r;
        c = n % ht;
        r = (n / ht) % vt;
        chk({p, "_col"}, col, 32'(c));
        chk({p, "_row"}, row, 32'(r));
        chk({p, "_inactive"}, 32'(si), 32'(c >= ha || r >= va));
        chk({p, "_cmd_en"}, 32'(cmd), 32'(r >= va));
        chk({p, "_frame_irq"}, 32'(fi), 32'(r == va && c == 0));
    endtask

    task automatic check_cycle();
        logic [5:0] er;
        logic eh, ev;
        model(n, 1, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0, 6'h3F, er, eh, ev);
        chk("big_rgb", 32'(b_rgb), 32'(er));
        chk("big_hsync", 32'(b_hs), 32'(eh));
        chk("big_vsync", 32'(b_vs), 32'(ev));
        chk_cnt("big", 800, 525, 640, 480, 32'(b_col), 32'(b_row), b_si, b_cmd, b_fi);
        model(n, 3, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0, 6'h2A, er, eh, ev);
        chk("p3_rgb", 32'(p_rgb), 32'(er));
        chk("p3_hsync", 32'(p_hs), 32'(eh));
        chk("p3_vsync", 32'(p_vs), 32'(ev));
        model(n, 1, 16, 2, 4, 24, 6, 1, 2, 10, 1'b1, 1'b0, 6'h15, er, eh, ev);
        chk("sm_rgb", 32'(s_rgb), 32'(er));
        chk("sm_hsync", 32'(s_hs), 32'(eh));
        chk("sm_vsync", 32'(s_vs), 32'(ev));
        chk_cnt("sm", 24, 10, 16, 6, 32'(s_col), 32'(s_row), s_si, s_cmd, s_fi);
    endtask

    task automatic check_reset();
        chk("rst_big_col", 32'(b_col), 32'd0);
        chk("rst_big_row", 32'(b_row), 32'd0);
        chk("rst_big_rgb", 32'(b_rgb), 32'd0);
        chk("rst_big_hsync", 32'(b_hs), 32'd1);
        chk("rst_big_vsync", 32'(b_vs), 32'd1);
        chk("rst_big_irq", 32'(b_fi), 32'd0);
        chk("rst_big_inactive", 32'(b_si), 32'd0);
        chk("rst_big_cmd_en", 32'(b_cmd), 32'd0);
        chk("rst_p3_col", 32'(p_col), 32'd0);
        chk("rst_p3_rgb", 32'(p_rgb), 32'd0);
        chk("rst_p3_hsync", 32'(p_hs), 32'd1);
        chk("rst_sm_col", 32'(s_col), 32'd0);
        chk("rst_sm_row", 32'(s_row), 32'd0);
        chk("rst_sm_hsync", 32'(s_hs), 32'd0);
        chk("rst_sm_vsync", 32'(s_vs), 32'd1);
        chk("rst_sm_rgb", 32'(s_rgb), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    // Release reset at a falling edge and walk the given number of cycles
    task automatic run_from_reset(input int cycles);
        rst_n = 1'b1;
        n = 0;
        check_cycle();
        for (int i = 1; i < cycles; i++) begin
            step();
            check_cycle();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        tp       = 1'b0;
        rst_n    = 1'b0;

        // Held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();

        // Two full default lines, several small frames
        run_from_reset(1602);

        // Asynchronous reset in the middle of a frame
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        check_reset();
        run_from_reset(60);

`ifdef TEST_PATTERN_EN
        // Colour bars replace pixel_in
        @(negedge clk);
        rst_n = 1'b0;
        tp    = 1'b1;
        @(negedge clk);
        check_reset();
        run_from_reset(900);
        tp = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
